icc_writer: RTL and testbench

Producer side of the integer condition codes (icc) consumed by the branch condition logic in ID. Captures ALU flags from cc-modifying instructions in EX and carries them through MEM and WB. Commits them to the architectural icc register at WB, and accepts explicit PSR icc writes. Supplies ID with the youngest in-flight flags and raises a stall when a branch in ID depends on a cc-modifier still in EX.

---
 rtl/icc_writer_pkg.sv | 23 ++
 rtl/icc_writer_if.sv | 34 +++
 rtl/icc_stage_reg.sv | 24 ++
 rtl/icc_writer.sv | 83 ++++++++
 tb/tb_icc_writer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/icc_writer_pkg.sv
// Shared definitions for the integer condition code producer and its consumers.
// Flag vectors are ordered [0]=Z, [1]=N, [2]=C, [3]=V everywhere.
package icc_writer_pkg;

  localparam int ICC_Z = 0;
  localparam int ICC_N = 1;
  localparam int ICC_C = 2;
  localparam int ICC_V = 3;
  localparam int ICC_W = 4;

  typedef struct packed {
    logic              cc_v;
    logic [ICC_W-1:0]  flags;
  } cc_stage_t;

  localparam cc_stage_t CC_STAGE_RESET = '{cc_v: 1'b0, flags: '0};

  // A cc-modifier only counts when it is a real, non-annulled instruction.
  function automatic logic cc_live(input logic valid, input logic cc_en, input logic flush);
    return valid & cc_en & ~flush;
  endfunction

endpackage

// File: rtl/icc_writer_if.sv
// Pipeline-facing bundle of the icc producer: EX capture, WB commit, ID forwarding.
// Stage contents are exported on dbg_mem/dbg_wb for observation.
interface icc_writer_if;
  import icc_writer_pkg::*;

  // ex_valid qualifies the EX fields for one cycle; there is no ready.
  // pipe_hold is the only back-pressure: while high, MEM, WB and icc keep their value.
  logic              ex_valid;
  logic              ex_cc_en;
  logic [ICC_W-1:0]  ex_alu_flags;
  logic              ex_flush;
  logic              pipe_hold;
  logic              wb_wr_icc;
  logic [ICC_W-1:0]  wb_wr_data;
  logic              id_branch_instr;
  logic [ICC_W-1:0]  flags_fwd;
  logic              stall_id;
  logic [ICC_W-1:0]  icc;
  cc_stage_t         dbg_mem;
  cc_stage_t         dbg_wb;

  modport master (
    output ex_valid, ex_cc_en, ex_alu_flags, ex_flush, pipe_hold,
           wb_wr_icc, wb_wr_data, id_branch_instr,
    input  flags_fwd, stall_id, icc, dbg_mem, dbg_wb
  );

  modport slave (
    input  ex_valid, ex_cc_en, ex_alu_flags, ex_flush, pipe_hold,
           wb_wr_icc, wb_wr_data, id_branch_instr,
    output flags_fwd, stall_id, icc, dbg_mem, dbg_wb
  );

endinterface

// File: rtl/icc_stage_reg.sv
// One pipeline stage of condition-code state: async-reset register with hold.
module icc_stage_reg
  import icc_writer_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      hold_i,
  input  cc_stage_t d_i,
  output cc_stage_t q_o
);

  cc_stage_t stage_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= CC_STAGE_RESET;
    end else if (!hold_i) begin
      stage_q <= d_i;
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/icc_writer.sv
// Carries ALU flags EX->MEM->WB, commits them to the architectural icc and
// feeds ID the youngest in-flight flags, stalling a branch behind an EX producer.
module icc_writer
  import icc_writer_pkg::*;
#(
  parameter logic [ICC_W-1:0] RESET_ICC   = 4'b0000,
  parameter bit               STALL_ON_EX = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  icc_writer_if.slave bus
);

  logic              ex_live;
  cc_stage_t         mem_d;
  cc_stage_t         mem_q;
  cc_stage_t         wb_q;
  logic [ICC_W-1:0]  icc_d;
  logic [ICC_W-1:0]  icc_q;
  logic [ICC_W-1:0]  fwd;

  assign ex_live = cc_live(bus.ex_valid, bus.ex_cc_en, bus.ex_flush);

  // Flags are captured unconditionally; cc_v alone decides whether they matter.
  assign mem_d = '{cc_v: ex_live, flags: bus.ex_alu_flags};

  icc_stage_reg u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold_i (bus.pipe_hold),
    .d_i    (mem_d),
    .q_o    (mem_q)
  );

  icc_stage_reg u_wb (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold_i (bus.pipe_hold),
    .d_i    (mem_q),
    .q_o    (wb_q)
  );

  // An explicit wrpsr in WB overrides the flags of the instruction retiring with it.
  always_comb begin
    icc_d = icc_q;
    if (!bus.pipe_hold) begin
      if (bus.wb_wr_icc) begin
        icc_d = bus.wb_wr_data;
      end else if (wb_q.cc_v) begin
        icc_d = wb_q.flags;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icc_q <= RESET_ICC;
    end else begin
      icc_q <= icc_d;
    end
  end

  // Youngest producer wins; EX is only a source when the branch is not stalled for it.
  always_comb begin
    fwd = icc_q;
    if (!STALL_ON_EX && ex_live) begin
      fwd = bus.ex_alu_flags;
    end else if (mem_q.cc_v) begin
      fwd = mem_q.flags;
    end else if (bus.wb_wr_icc) begin
      fwd = bus.wb_wr_data;
    end else if (wb_q.cc_v) begin
      fwd = wb_q.flags;
    end
  end

  assign bus.flags_fwd = fwd;
  assign bus.stall_id  = STALL_ON_EX & bus.id_branch_instr & ex_live;
  assign bus.icc       = icc_q;
  assign bus.dbg_mem   = mem_q;
  assign bus.dbg_wb    = wb_q;

endmodule

// File: tb/tb_icc_writer.sv
// Directed bench for icc_writer: a stalling instance (default parameters) and a
// forwarding instance (STALL_ON_EX=0, RESET_ICC=1001) driven with identical stimulus.
module tb_icc_writer;
  import icc_writer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  icc_writer_if bus_s ();
  icc_writer_if bus_f ();

  icc_writer u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  icc_writer #(.RESET_ICC(4'b1001), .STALL_ON_EX(1'b0)) u_dut_f (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_f)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic en, input logic fl, input logic [3:0] f);
    bus_s.ex_valid = v;  bus_f.ex_valid = v;
    bus_s.ex_cc_en = en; bus_f.ex_cc_en = en;
    bus_s.ex_flush = fl; bus_f.ex_flush = fl;
    bus_s.ex_alu_flags = f; bus_f.ex_alu_flags = f;
    #1;
  endtask

  task automatic set_ctl(input logic hold, input logic wr, input logic [3:0] wd, input logic br);
    bus_s.pipe_hold = hold; bus_f.pipe_hold = hold;
    bus_s.wb_wr_icc = wr;   bus_f.wb_wr_icc = wr;
    bus_s.wb_wr_data = wd;  bus_f.wb_wr_data = wd;
    bus_s.id_branch_instr = br; bus_f.id_branch_instr = br;
    #1;
  endtask

  task automatic idle();
    set_ex(1'b0, 1'b0, 1'b0, 4'b0000);
    set_ctl(1'b0, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus_s.icc !== 4'b0000) begin bad++; $display("FAIL reset_icc: got %b want 0000", bus_s.icc); end
    total++; if (bus_s.flags_fwd !== 4'b0000) begin bad++; $display("FAIL reset_fwd: got %b want 0000", bus_s.flags_fwd); end
    total++; if (bus_s.stall_id !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus_s.stall_id); end
    total++; if (bus_f.icc !== 4'b1001) begin bad++; $display("FAIL reset_icc_param: got %b want 1001", bus_f.icc); end
    total++; if (bus_f.flags_fwd !== 4'b1001) begin bad++; $display("FAIL reset_fwd_param: got %b want 1001", bus_f.flags_fwd); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_commit();
    set_ex(1'b1, 1'b1, 1'b0, 4'b0001);
    total++; if (bus_s.flags_fwd !== 4'b0000) begin bad++; $display("FAIL commit_fwd_ex_stallmode: got %b want 0000", bus_s.flags_fwd); end
    total++; if (bus_f.flags_fwd !== 4'b0001) begin bad++; $display("FAIL commit_fwd_ex_fwdmode: got %b want 0001", bus_f.flags_fwd); end
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 4'b0000);
    total++; if (bus_s.flags_fwd !== 4'b0001) begin bad++; $display("FAIL commit_fwd_mem: got %b want 0001", bus_s.flags_fwd); end
    total++; if (bus_s.icc !== 4'b0000) begin bad++; $display("FAIL commit_icc_e1: got %b want 0000", bus_s.icc); end
    tick();
    total++; if (bus_s.icc !== 4'b0000) begin bad++; $display("FAIL commit_icc_e2: got %b want 0000", bus_s.icc); end
    total++; if (bus_s.flags_fwd !== 4'b0001) begin bad++; $display("FAIL commit_fwd_wb: got %b want 0001", bus_s.flags_fwd); end
    tick();
    total++; if (bus_s.icc !== 4'b0001) begin bad++; $display("FAIL commit_icc_e3: got %b want 0001", bus_s.icc); end
    total++; if (bus_f.icc !== 4'b0001) begin bad++; $display("FAIL commit_icc_e3_fwdmode: got %b want 0001", bus_f.icc); end
  endtask

  task automatic test_hazard();
    set_ctl(1'b0, 1'b0, 4'b0000, 1'b1);
    set_ex(1'b1, 1'b1, 1'b0, 4'b0110);
    total++; if (bus_s.stall_id !== 1'b1) begin bad++; $display("FAIL hazard_stall: got %b want 1", bus_s.stall_id); end
    total++; if (bus_s.flags_fwd !== 4'b0001) begin bad++; $display("FAIL hazard_fwd_during_stall: got %b want 0001", bus_s.flags_fwd); end
    total++; if (bus_f.stall_id !== 1'b0) begin bad++; $display("FAIL hazard_no_stall_fwdmode: got %b want 0", bus_f.stall_id); end
    total++; if (bus_f.flags_fwd !== 4'b0110) begin bad++; $display("FAIL hazard_fwd_ex: got %b want 0110", bus_f.flags_fwd); end
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 4'b0000);
    total++; if (bus_s.stall_id !== 1'b0) begin bad++; $display("FAIL hazard_stall_cleared: got %b want 0", bus_s.stall_id); end
    total++; if (bus_s.flags_fwd !== 4'b0110) begin bad++; $display("FAIL hazard_fwd_mem: got %b want 0110", bus_s.flags_fwd); end
    set_ctl(1'b0, 1'b0, 4'b0000, 1'b0);
    tick();
    tick();
    total++; if (bus_s.icc !== 4'b0110) begin bad++; $display("FAIL hazard_icc: got %b want 0110", bus_s.icc); end
  endtask

  task automatic test_back_to_back();
    set_ex(1'b1, 1'b1, 1'b0, 4'b1000);
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 4'b0100);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 4'b0000);
    total++; if (bus_s.flags_fwd !== 4'b0100) begin bad++; $display("FAIL b2b_fwd_younger: got %b want 0100", bus_s.flags_fwd); end
    total++; if (bus_s.icc !== 4'b0110) begin bad++; $display("FAIL b2b_icc_pre: got %b want 0110", bus_s.icc); end
    tick();
    total++; if (bus_s.icc !== 4'b1000) begin bad++; $display("FAIL b2b_icc_older: got %b want 1000", bus_s.icc); end
    total++; if (bus_s.flags_fwd !== 4'b0100) begin bad++; $display("FAIL b2b_fwd_wb: got %b want 0100", bus_s.flags_fwd); end
    tick();
    total++; if (bus_s.icc !== 4'b0100) begin bad++; $display("FAIL b2b_icc_final: got %b want 0100", bus_s.icc); end
  endtask

  task automatic test_wrpsr();
    set_ex(1'b1, 1'b1, 1'b0, 4'b0001);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    set_ctl(1'b0, 1'b1, 4'b1111, 1'b0);
    total++; if (bus_s.flags_fwd !== 4'b1111) begin bad++; $display("FAIL wrpsr_fwd: got %b want 1111", bus_s.flags_fwd); end
    tick();
    set_ctl(1'b0, 1'b0, 4'b0000, 1'b0);
    total++; if (bus_s.icc !== 4'b1111) begin bad++; $display("FAIL wrpsr_icc: got %b want 1111", bus_s.icc); end
    total++; if (bus_s.flags_fwd !== 4'b1111) begin bad++; $display("FAIL wrpsr_fwd_after: got %b want 1111", bus_s.flags_fwd); end
  endtask

  task automatic test_flush();
    set_ctl(1'b0, 1'b0, 4'b0000, 1'b1);
    set_ex(1'b1, 1'b1, 1'b1, 4'b1010);
    total++; if (bus_s.stall_id !== 1'b0) begin bad++; $display("FAIL flush_no_stall: got %b want 0", bus_s.stall_id); end
    total++; if (bus_f.flags_fwd !== 4'b1111) begin bad++; $display("FAIL flush_no_ex_fwd: got %b want 1111", bus_f.flags_fwd); end
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 4'b0000);
    set_ctl(1'b0, 1'b0, 4'b0000, 1'b0);
    total++; if (bus_s.flags_fwd !== 4'b1111) begin bad++; $display("FAIL flush_no_capture: got %b want 1111", bus_s.flags_fwd); end
    tick();
    tick();
    total++; if (bus_s.icc !== 4'b1111) begin bad++; $display("FAIL flush_icc: got %b want 1111", bus_s.icc); end
  endtask

  task automatic test_hold();
    set_ex(1'b1, 1'b1, 1'b0, 4'b0011);
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 4'b1100);
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 4'b0101);
    set_ctl(1'b1, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus_s.icc !== 4'b1111) begin bad++; $display("FAIL hold_icc[%0d]: got %b want 1111", i, bus_s.icc); end
      total++; if (bus_s.flags_fwd !== 4'b1100) begin bad++; $display("FAIL hold_fwd[%0d]: got %b want 1100", i, bus_s.flags_fwd); end
    end
    set_ex(1'b0, 1'b0, 1'b0, 4'b0000);
    set_ctl(1'b0, 1'b0, 4'b0000, 1'b0);
    tick();
    total++; if (bus_s.icc !== 4'b0011) begin bad++; $display("FAIL hold_resume_icc1: got %b want 0011", bus_s.icc); end
    total++; if (bus_s.flags_fwd !== 4'b1100) begin bad++; $display("FAIL hold_resume_fwd: got %b want 1100", bus_s.flags_fwd); end
    tick();
    total++; if (bus_s.icc !== 4'b1100) begin bad++; $display("FAIL hold_resume_icc2: got %b want 1100", bus_s.icc); end
  endtask

  task automatic test_reset_mid();
    set_ex(1'b1, 1'b1, 1'b0, 4'b0101);
    tick();
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 4'b0000);
    total++; if (bus_s.flags_fwd !== 4'b0101) begin bad++; $display("FAIL midrst_pre_fwd: got %b want 0101", bus_s.flags_fwd); end
    rst_n = 1'b0;
    #1;
    total++; if (bus_s.icc !== 4'b0000) begin bad++; $display("FAIL midrst_icc: got %b want 0000", bus_s.icc); end
    total++; if (bus_s.flags_fwd !== 4'b0000) begin bad++; $display("FAIL midrst_fwd: got %b want 0000", bus_s.flags_fwd); end
    total++; if (bus_s.stall_id !== 1'b0) begin bad++; $display("FAIL midrst_stall: got %b want 0", bus_s.stall_id); end
    total++; if (bus_f.icc !== 4'b1001) begin bad++; $display("FAIL midrst_icc_param: got %b want 1001", bus_f.icc); end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    total++; if (bus_s.icc !== 4'b0000) begin bad++; $display("FAIL midrst_discard: got %b want 0000", bus_s.icc); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_hazard();
    test_back_to_back();
    test_wrpsr();
    test_flush();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
